// File: rtl/axistream_packet_arbiter_if.sv
// Handshake bundle for the packet arbiter: NUM_SRC AXI-stream sources in, one shared stream out.
interface axistream_packet_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4
);
    logic [NUM_SRC-1:0]            src_tvalid;
    logic [NUM_SRC-1:0]            src_tready;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata;
    logic [NUM_SRC-1:0]            src_tlast;
    logic                          dest_tvalid;
    logic                          dest_tready;
    logic [DATA_WIDTH-1:0]         dest_tdata;
    logic                          dest_tlast;

    // Arbiter view: consumes the sources, drives the shared output.
    modport slave (
        input  src_tvalid, src_tdata, src_tlast, dest_tready,
        output src_tready, dest_tvalid, dest_tdata, dest_tlast
    );

    // Environment view: drives the sources, consumes the shared output.
    modport master (
        output src_tvalid, src_tdata, src_tlast, dest_tready,
        input  src_tready, dest_tvalid, dest_tdata, dest_tlast
    );
endinterface

// File: rtl/axistream_packet_arbiter.sv
// Round-robin arbiter that locks the shared AXI-stream output to one source for a whole packet.
module axistream_packet_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_SRC    = 4,
    localparam int IDX_W      = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    axistream_packet_arbiter_if.slave bus,
    output logic                     grant_valid,
    output logic [IDX_W-1:0]         grant_idx
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                             state, state_d;
    logic   [IDX_W-1:0]                 last_idx;
    logic   [IDX_W-1:0]                 pick, cand;
    logic                               found, busy, beat;
    logic   [NUM_SRC-1:0]               rdy;
    logic   [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;

    assign src_data = bus.src_tdata;
    assign busy     = !rst && (state == BUSY);
    assign beat     = bus.dest_tvalid && bus.dest_tready;

    // State register; grant is captured on the IDLE->BUSY edge, last winner on packet end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_W'(NUM_SRC - 1);
        end else begin
            state <= state_d;
            if (state == IDLE && found)
                grant_idx <= pick;
            if (state == BUSY && state_d == IDLE)
                last_idx <= grant_idx;
        end
    end

    // Search starts one past the previous winner and wraps, so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        pick    = grant_idx;
        cand    = '0;
        state_d = state;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = IDX_W'((int'(last_idx) + i) % NUM_SRC);
            if (!found && bus.src_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        case (state)
            IDLE:    if (found) state_d = BUSY;
            default: if (beat && bus.dest_tlast) state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_valid     = busy;
        bus.dest_tvalid = 1'b0;
        bus.dest_tdata  = '0;
        bus.dest_tlast  = 1'b0;
        if (busy) begin
            bus.dest_tvalid = bus.src_tvalid[grant_idx];
            bus.dest_tdata  = src_data[grant_idx];
            bus.dest_tlast  = bus.src_tlast[grant_idx];
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
        assign rdy[k] = busy && (grant_idx == IDX_W'(k)) && bus.dest_tready;
    end
    assign bus.src_tready = rdy;
endmodule

// File: tb/tb_axistream_packet_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a packet-level model.
module tb_axistream_packet_arbiter;
    localparam int DW = 8;
    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       gv;
    logic [1:0] gidx;

    axistream_packet_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

    axistream_packet_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .grant_valid(gv),
        .grant_idx  (gidx)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] srcq [NS][$];   // {tlast, tdata} beats still to be offered by each source
    int         hold_off [NS];
    bit         hs [NS];
    bit         rand_gaps = 1'b0;

    // Sources present their queue head, hold it until accepted, then optionally idle.
    task automatic drive_srcs();
        for (int k = 0; k < NS; k++) begin
            if (hs[k]) begin
                void'(srcq[k].pop_front());
                hs[k] = 1'b0;
                if (rand_gaps) hold_off[k] = $urandom_range(0, 2);
            end
            if (hold_off[k] > 0) begin
                bus.src_tvalid[k] = 1'b0;
                hold_off[k]--;
            end else if (srcq[k].size() > 0) begin
                bus.src_tvalid[k]          = 1'b1;
                bus.src_tdata[k*DW +: DW]  = srcq[k][0][7:0];
                bus.src_tlast[k]           = srcq[k][0][8];
            end else begin
                bus.src_tvalid[k] = 1'b0;
            end
        end
    endtask

    // One clock: drive 1 after the edge, sample 3 after the edge.
    task automatic step(input logic r_dy, input logic r_st);
        @(posedge clk);
        #1;
        rst = r_st;
        drive_srcs();
        bus.dest_tready = r_dy;
        #2;
        for (int k = 0; k < NS; k++) hs[k] = bus.src_tvalid[k] && bus.src_tready[k];
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < NS; k++) begin
            srcq[k].delete();
            hold_off[k] = 0;
            hs[k]       = 1'b0;
        end
    endtask

    task automatic do_reset();
        clear_srcs();
        step(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        clear_srcs();
        rst = 1'b1;
        for (int k = 0; k < NS; k++) srcq[k].push_back({1'b1, 8'(k)});
        drive_srcs();
        bus.dest_tready = 1'b1;
        #3;
        for (int c = 0; c < 2; c++) begin
            if (c == 1) step(1'b1, 1'b1);
            total += 3;
            if (bus.dest_tvalid !== 1'b0) begin bad++; $display("FAIL reset_dvalid c%0d: got %b want 0", c, bus.dest_tvalid); end
            if (bus.src_tready !== 4'b0) begin bad++; $display("FAIL reset_sready c%0d: got %b want 0000", c, bus.src_tready); end
            if (gv !== 1'b0) begin bad++; $display("FAIL reset_gv c%0d: got %b want 0", c, gv); end
        end
        step(1'b1, 1'b0);
        total++;
        if (gv !== 1'b0) begin bad++; $display("FAIL reset_idle: got gv=%b want 0", gv); end
        step(1'b1, 1'b0);
        total += 2;
        if (gv !== 1'b1) begin bad++; $display("FAIL reset_first_gv: got %b want 1", gv); end
        if (gidx !== 2'd0) begin bad++; $display("FAIL reset_first_idx: got %0d want 0", gidx); end
    endtask

    task automatic test_round_robin();
        logic [7:0] got[$];
        int         cyc[$];
        logic [7:0] want [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        for (int k = 0; k < NS; k++) srcq[k].push_back({1'b1, 8'(8'h10 + k)});
        srcq[0].push_back({1'b1, 8'h10});
        for (int c = 0; c < 14; c++) begin
            step(1'b1, 1'b0);
            if (bus.dest_tvalid && bus.dest_tready) begin
                got.push_back(bus.dest_tdata);
                cyc.push_back(c);
            end
        end
        total++;
        if (got.size() != 5) begin bad++; $display("FAIL rr_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            total++;
            if (got[i] !== want[i]) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, got[i], want[i]); end
            if (i > 0) begin
                total++;
                if (cyc[i] - cyc[i-1] != 2) begin bad++; $display("FAIL rr_spacing[%0d]: got %0d want 2", i, cyc[i] - cyc[i-1]); end
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] got[$];
        logic [1:0] gi[$];
        logic [7:0] want [4] = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
        logic [1:0] wsrc [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        do_reset();
        srcq[1].push_back({1'b0, 8'hA0});
        srcq[1].push_back({1'b0, 8'hA1});
        srcq[1].push_back({1'b1, 8'hA2});
        step(1'b1, 1'b0);
        srcq[0].push_back({1'b1, 8'h55});
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0);
            if (bus.dest_tvalid && bus.dest_tready) begin
                got.push_back(bus.dest_tdata);
                gi.push_back(gidx);
            end
        end
        total++;
        if (got.size() != 4) begin bad++; $display("FAIL lock_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total += 2;
            if (got[i] !== want[i]) begin bad++; $display("FAIL lock_data[%0d]: got %h want %h", i, got[i], want[i]); end
            if (gi[i] !== wsrc[i]) begin bad++; $display("FAIL lock_src[%0d]: got %0d want %0d", i, gi[i], wsrc[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic       r;
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) srcq[0].push_back({(i == 3), 8'(8'hB0 + i)});
        for (int c = 0; c < 16; c++) begin
            r = (c % 2 == 0);
            step(r, 1'b0);
            if (gv) begin
                exp_rdy = r ? 4'b0001 : 4'b0000;
                total++;
                if (bus.src_tready !== exp_rdy) begin bad++; $display("FAIL bp_sready c%0d: got %b want %b", c, bus.src_tready, exp_rdy); end
            end
            if (bus.dest_tvalid && bus.dest_tready) got.push_back(bus.dest_tdata);
        end
        total++;
        if (got.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++;
            if (got[i] !== 8'(8'hB0 + i)) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], 8'(8'hB0 + i)); end
        end
    endtask

    task automatic test_source_stall();
        logic [7:0] got[$];
        int         stall_left = 0;
        bit         stalled    = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) srcq[2].push_back({(i == 3), 8'(8'hC0 + i)});
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 1'b0);
            if (stall_left > 0) begin
                total += 3;
                if (bus.dest_tvalid !== 1'b0) begin bad++; $display("FAIL stall_dvalid c%0d: got %b want 0", c, bus.dest_tvalid); end
                if (gv !== 1'b1) begin bad++; $display("FAIL stall_gv c%0d: got %b want 1", c, gv); end
                if (gidx !== 2'd2) begin bad++; $display("FAIL stall_idx c%0d: got %0d want 2", c, gidx); end
                stall_left--;
            end
            if (bus.dest_tvalid && bus.dest_tready) got.push_back(bus.dest_tdata);
            if (!stalled && got.size() == 2) begin
                hold_off[2] = 3;
                stall_left  = 3;
                stalled     = 1'b1;
            end
        end
        total++;
        if (got.size() != 4) begin bad++; $display("FAIL stall_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++;
            if (got[i] !== 8'(8'hC0 + i)) begin bad++; $display("FAIL stall_data[%0d]: got %h want %h", i, got[i], 8'(8'hC0 + i)); end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < 3; i++) srcq[1].push_back({(i == 2), 8'(8'hE0 + i)});
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        total += 3;
        if (bus.dest_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_dvalid: got %b want 0", bus.dest_tvalid); end
        if (bus.src_tready !== 4'b0) begin bad++; $display("FAIL rmid_sready: got %b want 0000", bus.src_tready); end
        if (gv !== 1'b0) begin bad++; $display("FAIL rmid_gv: got %b want 0", gv); end
        clear_srcs();
        srcq[3].push_back({1'b1, 8'hD3});
        step(1'b1, 1'b0);
        total++;
        if (gv !== 1'b0) begin bad++; $display("FAIL rmid_idle: got gv=%b want 0", gv); end
        step(1'b1, 1'b0);
        total += 3;
        if (gv !== 1'b1) begin bad++; $display("FAIL rmid_gv2: got %b want 1", gv); end
        if (gidx !== 2'd3) begin bad++; $display("FAIL rmid_idx: got %0d want 3", gidx); end
        if (bus.dest_tdata !== 8'hD3 || bus.dest_tvalid !== 1'b1) begin
            bad++; $display("FAIL rmid_data: got v=%b d=%h want v=1 d=d3", bus.dest_tvalid, bus.dest_tdata);
        end
    endtask

    // Random traffic: model tracks expected beats per source, packet ownership and the round-robin pointer.
    task automatic test_random();
        logic [8:0] exp_q [NS][$];
        logic [8:0] e;
        logic [3:0] prev_val = '0;
        logic [3:0] exp_rdy;
        logic [1:0] prev_idx = '0;
        logic       r, prev_gv = 1'b0, prev_last = 1'b0, bt;
        int         model_last = NS - 1;
        int         owner = -1;
        int         pick, left, len;
        do_reset();
        rand_gaps = 1'b1;
        for (int k = 0; k < NS; k++) begin
            for (int p = $urandom_range(1, 3); p > 0; p--) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    e = {(b == len - 1), 8'($urandom)};
                    srcq[k].push_back(e);
                    exp_q[k].push_back(e);
                end
            end
        end
        for (int c = 0; c < 2000; c++) begin
            left = 0;
            for (int k = 0; k < NS; k++) left += exp_q[k].size();
            if (left == 0) break;
            r = ($urandom_range(0, 3) != 0);
            step(r, 1'b0);
            total++;
            if (!$onehot0(bus.src_tready)) begin bad++; $display("FAIL rnd_onehot c%0d: got %b want at most one bit", c, bus.src_tready); end
            if (prev_last) begin
                total++;
                if (gv !== 1'b0) begin bad++; $display("FAIL rnd_gap c%0d: got gv=%b want 0", c, gv); end
            end else if (!prev_gv) begin
                total++;
                if (gv !== (|prev_val)) begin bad++; $display("FAIL rnd_arb_gv c%0d: got %b want %b", c, gv, |prev_val); end
                if (gv && |prev_val) begin
                    pick = -1;
                    for (int i = 1; i <= NS; i++)
                        if (pick < 0 && prev_val[(model_last + i) % NS]) pick = (model_last + i) % NS;
                    total++;
                    if (int'(gidx) != pick) begin bad++; $display("FAIL rnd_rr c%0d: got %0d want %0d", c, gidx, pick); end
                end
            end else begin
                total++;
                if (gv !== 1'b1 || gidx !== prev_idx) begin
                    bad++; $display("FAIL rnd_hold c%0d: got gv=%b idx=%0d want gv=1 idx=%0d", c, gv, gidx, prev_idx);
                end
            end
            if (gv) begin
                exp_rdy = r ? (4'b0001 << gidx) : 4'b0000;
                total += 2;
                if (bus.src_tready !== exp_rdy) begin bad++; $display("FAIL rnd_sready c%0d: got %b want %b", c, bus.src_tready, exp_rdy); end
                if (bus.dest_tvalid !== bus.src_tvalid[gidx]) begin bad++; $display("FAIL rnd_dvalid c%0d: got %b want %b", c, bus.dest_tvalid, bus.src_tvalid[gidx]); end
            end
            bt = bus.dest_tvalid && r;
            if (bt) begin
                total += 2;
                if (exp_q[gidx].size() == 0) begin
                    bad++; $display("FAIL rnd_extra c%0d: got beat from src %0d want none", c, gidx);
                end else begin
                    e = exp_q[gidx].pop_front();
                    if ({bus.dest_tlast, bus.dest_tdata} !== e) begin
                        bad++; $display("FAIL rnd_data c%0d: got %h want %h", c, {bus.dest_tlast, bus.dest_tdata}, e);
                    end
                end
                if (owner >= 0 && owner != int'(gidx)) begin bad++; $display("FAIL rnd_lock c%0d: got src %0d want %0d", c, gidx, owner); end
                owner = int'(gidx);
                if (bus.dest_tlast) begin
                    owner      = -1;
                    model_last = int'(gidx);
                end
            end
            prev_gv   = gv;
            prev_idx  = gidx;
            prev_val  = bus.src_tvalid;
            prev_last = bt && bus.dest_tlast;
        end
        left = 0;
        for (int k = 0; k < NS; k++) left += exp_q[k].size();
        total++;
        if (left != 0) begin bad++; $display("FAIL rnd_drain: got %0d beats outstanding want 0", left); end
        rand_gaps = 1'b0;
    endtask

    initial begin
        bus.src_tvalid  = '0;
        bus.src_tdata   = '0;
        bus.src_tlast   = '0;
        bus.dest_tready = 1'b0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_source_stall();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
